// File: rtl/mcu_pkg.sv
// Shared MCU definitions: opcode map, sequencer state encoding and datapath width.
package mcu_pkg;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 4;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ALU_MIN = 4'h1;
    localparam logic [3:0] OP_ALU_MAX = 4'h7;
    localparam logic [3:0] OP_JMP     = 4'h8;
    localparam logic [3:0] OP_JZ      = 4'h9;
    localparam logic [3:0] OP_HLT     = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_FETCH_IMM,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational instruction-class decode of the opcode field.
module opcode_decoder
    import mcu_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    output logic             is_alu,
    output logic             is_jmp,
    output logic             is_jz,
    output logic             is_hlt
);

    // Opcodes outside these classes (NOP and 0xA-0xE) fall through to plain fetch.
    always_comb begin
        is_alu = (opcode >= OPC_W'(OP_ALU_MIN)) && (opcode <= OPC_W'(OP_ALU_MAX));
        is_jmp = (opcode == OPC_W'(OP_JMP));
        is_jz  = (opcode == OPC_W'(OP_JZ));
        is_hlt = (opcode == OPC_W'(OP_HLT));
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch/decode/execute FSM that owns every PC update.
module cpu_sequencer
    import mcu_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] pc_value,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [DATA_W-1:0] pc_target,
    input  logic              zero_flag,
    output logic [DATA_W-1:0] ir,
    output logic [OPC_W-1:0]  alu_op,
    output logic              alu_en,
    output logic              reg_we,
    output logic              halted
);

    seq_state_t state;
    logic       is_alu;
    logic       is_jmp;
    logic       is_jz;
    logic       is_hlt;
    logic       fetch_ack;
    logic       imm_ack;
    logic       taken;

    opcode_decoder #(
        .OPC_W (OPC_W)
    ) u_opcode_decoder (
        .opcode (ir[DATA_W-1 -: OPC_W]),
        .is_alu (is_alu),
        .is_jmp (is_jmp),
        .is_jz  (is_jz),
        .is_hlt (is_hlt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ir    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_alu)               state <= ST_EXEC;
                    else if (is_jmp || is_jz) state <= ST_FETCH_IMM;
                    else if (is_hlt)          state <= ST_HALT;
                    else                      state <= ST_FETCH;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                end
                ST_FETCH_IMM: begin
                    if (mem_ack) state <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The PC clears itself without a strobe, so every cycle that neither
    // increments nor branches reloads the current value instead.
    always_comb begin
        mem_req   = (state == ST_FETCH) || (state == ST_FETCH_IMM);
        fetch_ack = (state == ST_FETCH) && mem_ack;
        imm_ack   = (state == ST_FETCH_IMM) && mem_ack;
        taken     = imm_ack && (is_jmp || (is_jz && zero_flag));
        pc_inc    = fetch_ack || (imm_ack && !taken);
        pc_load   = !pc_inc;
        pc_target = taken ? mem_rdata : pc_value;
        alu_en    = (state == ST_EXEC);
        reg_we    = (state == ST_EXEC);
        halted    = (state == ST_HALT);
        alu_op    = ir[DATA_W-1 -: OPC_W];
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: PC block and memory models around the DUT, with an
// instruction-level trace model checked cycle by cycle plus literal expectations.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] pc_value;
    logic       pc_load;
    logic       pc_inc;
    logic [7:0] pc_target;
    logic       zero_flag;
    logic [7:0] ir;
    logic [3:0] alu_op;
    logic       alu_en;
    logic       reg_we;
    logic       halted;

    always #5 clk = ~clk;

    cpu_sequencer #(.OPC_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc_value  (pc_value),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .pc_target (pc_target),
        .zero_flag (zero_flag),
        .ir        (ir),
        .alu_op    (alu_op),
        .alu_en    (alu_en),
        .reg_we    (reg_we),
        .halted    (halted)
    );

    typedef struct {
        bit         req;
        bit         inc;
        bit         load;
        bit         alu;
        bit         hlt;
        logic [7:0] tgt;
        logic [7:0] irv;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mem [256];
    int         lat;
    bit         spur;
    int         wcnt;
    logic [7:0] pc;
    logic       last_load;
    logic       last_inc;
    logic [7:0] last_tgt;
    int         n_chk;
    int         n_fail;
    int         cyc;

    int         obs_inc;
    int         obs_alu;
    logic [3:0] alu_op_seen;
    logic [7:0] alu_ir_seen;
    int         n_branch;
    logic [7:0] branch_tgt;
    bit         pend_jmp;
    logic [7:0] first_req_pc;
    bit         seen_inc;
    int         req_before;
    bit         ir_early;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic push(input bit req, input bit inc, input bit load, input bit alu,
                        input bit hlt, input logic [7:0] tgt, input logic [7:0] irv);
        exp_t e;
        e.req = req; e.inc = inc; e.load = load; e.alu = alu; e.hlt = hlt;
        e.tgt = tgt; e.irv = irv;
        expq.push_back(e);
    endtask

    // Instruction-level model: walks the program from PC 0 after reset and
    // emits the per-cycle bus picture each instruction class must produce.
    task automatic gen(input int halt_cycles, input bit zf);
        logic [7:0] p = 8'h00;
        logic [7:0] r = 8'h00;
        logic [3:0] op;
        int         guard = 0;
        bit         done = 0;
        while (!done && guard < 64) begin
            guard++;
            repeat (lat) push(1, 0, 1, 0, 0, p, r);
            push(1, 1, 0, 0, 0, 8'h00, r);
            r = mem[p];
            p = p + 8'd1;
            push(0, 0, 1, 0, 0, p, r);
            op = r[7:4];
            if (op >= 4'd1 && op <= 4'd7) begin
                push(0, 0, 1, 1, 0, p, r);
            end else if (op == 4'd8 || op == 4'd9) begin
                repeat (lat) push(1, 0, 1, 0, 0, p, r);
                if (op == 4'd8 || zf) begin
                    push(1, 0, 1, 0, 0, mem[p], r);
                    p = mem[p];
                end else begin
                    push(1, 1, 0, 0, 0, 8'h00, r);
                    p = p + 8'd1;
                end
            end else if (op == 4'hF) begin
                repeat (halt_cycles) push(0, 0, 1, 0, 1, p, r);
                done = 1;
            end
        end
    endtask

    task automatic clr_obs();
        obs_inc = 0; obs_alu = 0; alu_op_seen = 4'h0; alu_ir_seen = 8'h00;
        n_branch = 0; branch_tgt = 8'h00; pend_jmp = 0; first_req_pc = 8'h00;
        seen_inc = 0; req_before = 0; ir_early = 0;
    endtask

    // One clock: PC block and memory respond at the falling edge, outputs are
    // compared against the model 1 ns later.
    task automatic step(input bit run_v);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (reset)          begin pc = 8'h00; wcnt = 0; end
        else if (last_load) pc = last_tgt;
        else if (last_inc)  pc = pc + 8'd1;
        else                pc = 8'h00;
        pc_value  = pc;
        run       = run_v;
        mem_rdata = mem[pc];
        mem_ack   = 1'b0;
        if (mem_req === 1'b1 && !reset) begin
            if (wcnt >= lat) begin mem_ack = 1'b1; wcnt = 0; end
            else wcnt++;
        end else begin
            wcnt = 0;
            mem_ack = spur && !reset;
        end
        #1;
        if (expq.size() == 0) begin
            check("model queue underflow", 1, 0);
        end else begin
            e = expq.pop_front();
            check("mem_req", mem_req, e.req);
            check("pc_inc",  pc_inc,  e.inc);
            check("pc_load", pc_load, e.load);
            if (e.load) check("pc_target", pc_target, e.tgt);
            check("alu_en",  alu_en,  e.alu);
            check("reg_we",  reg_we,  e.alu);
            check("halted",  halted,  e.hlt);
            check("ir",      ir,      e.irv);
            check("alu_op",  alu_op,  e.irv[7:4]);
        end
        if (pc_inc) obs_inc++;
        if (alu_en) begin obs_alu++; alu_op_seen = alu_op; alu_ir_seen = ir; end
        if (pend_jmp && mem_req) begin first_req_pc = pc_value; pend_jmp = 0; end
        if (pc_load && pc_target !== pc_value) begin
            n_branch++; branch_tgt = pc_target; pend_jmp = 1;
        end
        if (!seen_inc) begin
            if (mem_req) req_before++;
            if (ir !== 8'h00) ir_early = 1;
            if (pc_inc) seen_inc = 1;
        end
        last_load = pc_load;
        last_inc  = pc_inc;
        last_tgt  = pc_target;
    endtask

    task automatic do_reset();
        expq.delete();
        reset = 1'b1;
        spur  = 0;
        repeat (2) push(0, 0, 1, 0, 0, 8'h00, 8'h00);
        repeat (2) step(0);
        reset = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        int n;
        reset = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        pc_value = 8'h00; pc = 8'h00; zero_flag = 1'b0; spur = 0; lat = 0; wcnt = 0;
        last_load = 1'b1; last_inc = 1'b0; last_tgt = 8'h00;
        n_chk = 0; n_fail = 0; cyc = 0;
        clr_obs();
        clear_mem();

        do_reset();
        check("reset ir", ir, 8'h00);
        check("reset hold load", pc_load, 1'b1);

        // NOP, ALU 0x35, JMP 0x40, JZ not taken, illegal, HLT; zero-wait memory,
        // spurious acks while no request is outstanding
        clear_mem();
        mem[8'h00] = 8'h00; mem[8'h01] = 8'h35; mem[8'h02] = 8'h80; mem[8'h03] = 8'h40;
        mem[8'h40] = 8'h90; mem[8'h41] = 8'h10; mem[8'h42] = 8'hA5; mem[8'h43] = 8'hF0;
        do_reset();
        spur = 1; lat = 0; zero_flag = 1'b0;
        clr_obs();
        push(0, 0, 1, 0, 0, 8'h00, 8'h00);
        gen(4, 0);
        n = expq.size();
        check("t1 model length", n, 20);
        for (int i = 0; i < n; i++) step(i == 0 ? 1'b1 : (i >= n - 4 ? 1'(i % 2) : 1'b0));
        check("t1 pc_inc count", obs_inc, 7);
        check("t1 alu_en count", obs_alu, 1);
        check("t1 alu_op in exec", alu_op_seen, 4'h3);
        check("t1 ir in exec", alu_ir_seen, 8'h35);
        check("t1 branch count", n_branch, 1);
        check("t1 branch target", branch_tgt, 8'h40);
        check("t1 fetch pc after jmp", first_req_pc, 8'h40);
        check("t1 halted", halted, 1'b1);

        // JZ taken with three memory wait cycles per access
        clear_mem();
        mem[8'h00] = 8'h90; mem[8'h01] = 8'h20; mem[8'h20] = 8'hF0;
        do_reset();
        lat = 3; zero_flag = 1'b1;
        clr_obs();
        push(0, 0, 1, 0, 0, 8'h00, 8'h00);
        gen(3, 1);
        n = expq.size();
        check("t2 model length", n, 18);
        for (int i = 0; i < n; i++) step(i == 0 ? 1'b1 : (i >= n - 3 ? 1'(i % 2) : 1'b0));
        check("t2 req cycles first fetch", req_before, 4);
        check("t2 ir stable while waiting", ir_early, 0);
        check("t2 branch count", n_branch, 1);
        check("t2 branch target", branch_tgt, 8'h20);
        check("t2 halted", halted, 1'b1);

        // Reset asserted while a fetch is waiting for its ack
        clear_mem();
        mem[8'h00] = 8'h35; mem[8'h01] = 8'hF0;
        do_reset();
        lat = 3; zero_flag = 1'b0;
        clr_obs();
        push(0, 0, 1, 0, 0, 8'h00, 8'h00);
        gen(0, 0);
        step(1);
        repeat (8) step(0);
        check("t3 ir before abort", ir, 8'h35);
        check("t3 in fetch before abort", mem_req, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("t3 abort mem_req", mem_req, 1'b0);
        check("t3 abort pc_inc", pc_inc, 1'b0);
        check("t3 abort pc_load", pc_load, 1'b1);
        check("t3 abort pc_target", pc_target, pc_value);
        check("t3 abort alu_en", alu_en, 1'b0);
        check("t3 abort reg_we", reg_we, 1'b0);
        check("t3 abort halted", halted, 1'b0);
        check("t3 abort ir", ir, 8'h00);
        expq.delete();
        repeat (2) push(0, 0, 1, 0, 0, 8'h00, 8'h00);
        repeat (2) step(0);
        reset = 1'b0;
        repeat (3) push(0, 0, 1, 0, 0, 8'h00, 8'h00);
        repeat (3) step(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
